// File: rtl/icache_pkg.sv
// icache_pkg: shared types and geometry helpers
// for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic int woff_w(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(
    input int addr_w,
    input int lines,
    input int wpl
  );
    return addr_w - 2 - $clog2(wpl) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// icache_line_ram: LINES x WPL word store,
// one write port, one async read port.
module icache_line_ram #(
  parameter int LINES  = 16,
  parameter int WPL    = 4,
  parameter int DATA_W = 32,
  localparam int IW    = $clog2(LINES),
  localparam int OW    = $clog2(WPL)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IW-1:0]     i_widx,
  input  logic [OW-1:0]     i_wword,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IW-1:0]     i_ridx,
  input  logic [OW-1:0]     i_rword,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [LINES*WPL];

  // refill writes land on the same edge as the ack
  always_ff @(negedge i_clk) begin
    if (i_we) r_mem[{i_widx, i_wword}] <= i_wdata;
  end

  assign o_rdata = r_mem[{i_ridx, i_rword}];

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache
// with line refill FSM and global flush.
module icache_dm
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WPL    = 4
) (
  input  logic              PHI1,
  input  logic              MRST,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  input  logic              IFlush,
  output logic [DATA_W-1:0] IIn,
  output logic              IValid,
  output logic              IStall,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemData
);

  localparam int OW = woff_w(WPL);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(ADDR_W, LINES, WPL);

  state_t            r_state;
  logic [LINES-1:0]  r_valid;
  logic [TW-1:0]     r_tag [LINES];
  logic [IW-1:0]     r_idx;
  logic [TW-1:0]     r_ltag;
  logic [OW-1:0]     r_woff;
  logic [OW-1:0]     r_cnt;
  logic              r_fpend;
  logic [DATA_W-1:0] r_iin;
  logic              r_ivalid;
  logic              r_istall;
  logic              r_memreq;
  logic [ADDR_W-1:0] r_memaddr;

  logic [OW-1:0]     w_woff;
  logic [IW-1:0]     w_idx;
  logic [TW-1:0]     w_tag;
  logic              w_hit;
  logic              w_last;
  logic              w_we;
  logic              w_idle;
  logic [IW-1:0]     w_ridx;
  logic [OW-1:0]     w_rword;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  assign w_woff   = IAddr[2 +: OW];
  assign w_idx    = IAddr[2+OW +: IW];
  assign w_tag    = IAddr[ADDR_W-1 -: TW];
  assign w_unused = ^IAddr[1:0];

  // a flush on the request edge forces a miss
  assign w_hit  = r_valid[w_idx] &&
                  (r_tag[w_idx] == w_tag) &&
                  !IFlush;
  assign w_last = (r_cnt == OW'(WPL - 1));
  assign w_we   = (r_state == S_FILL) &&
                  r_memreq && MemAck;
  assign w_idle = (r_state == S_IDLE);

  // idle reads use the live address, RESP the latched one
  assign w_ridx  = w_idle ? w_idx  : r_idx;
  assign w_rword = w_idle ? w_woff : r_woff;

  icache_line_ram #(
    .LINES  (LINES),
    .WPL    (WPL),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (PHI1),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wword (r_cnt),
    .i_wdata (MemData),
    .i_ridx  (w_ridx),
    .i_rword (w_rword),
    .o_rdata (w_rdata)
  );

  // tag store, written when the refilled line is committed
  always_ff @(negedge PHI1) begin
    if (r_state == S_RESP) r_tag[r_idx] <= r_ltag;
  end

  // lookup / refill FSM with registered fetch and memory outputs
  always_ff @(negedge PHI1 or posedge MRST) begin
    if (MRST) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_idx     <= '0;
      r_ltag    <= '0;
      r_woff    <= '0;
      r_cnt     <= '0;
      r_fpend   <= 1'b0;
      r_iin     <= '0;
      r_ivalid  <= 1'b0;
      r_istall  <= 1'b0;
      r_memreq  <= 1'b0;
      r_memaddr <= '0;
    end else begin
      r_ivalid <= 1'b0;
      if (IFlush) r_valid <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (IReq) begin
            if (w_hit) begin
              r_iin    <= w_rdata;
              r_ivalid <= 1'b1;
            end else begin
              r_idx     <= w_idx;
              r_ltag    <= w_tag;
              r_woff    <= w_woff;
              r_cnt     <= '0;
              r_istall  <= 1'b1;
              r_memreq  <= 1'b1;
              r_memaddr <= {w_tag, w_idx,
                            {OW{1'b0}}, 2'b00};
              r_state   <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (IFlush) r_fpend <= 1'b1;
          if (MemAck) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_memreq <= 1'b0;
              r_state  <= S_RESP;
            end else begin
              r_memaddr <= r_memaddr + ADDR_W'(4);
            end
          end
        end
        S_RESP: begin
          r_valid[r_idx] <= !(r_fpend || IFlush);
          r_iin    <= w_rdata;
          r_ivalid <= 1'b1;
          r_istall <= 1'b0;
          r_fpend  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IIn     = r_iin;
  assign IValid  = r_ivalid;
  assign IStall  = r_istall;
  assign MemReq  = r_memreq;
  assign MemAddr = r_memaddr;

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: random + directed fetches
// against a line-level cache model.
module tb_icache_dm;

  localparam int LN = 16;
  localparam int WP = 4;

  logic        PHI1 = 1'b1;
  logic        MRST = 1'b0;
  logic        IReq = 1'b0;
  logic [31:0] IAddr = '0;
  logic        IFlush = 1'b0;
  logic [31:0] IIn;
  logic        IValid;
  logic        IStall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemData = '0;

  int n_chk = 0;
  int n_fail = 0;

  bit          mv [LN];
  logic [31:0] mt [LN];

  icache_dm #(
    .ADDR_W (32),
    .DATA_W (32),
    .LINES  (LN),
    .WPL    (WP)
  ) dut (
    .PHI1    (PHI1),
    .MRST    (MRST),
    .IReq    (IReq),
    .IAddr   (IAddr),
    .IFlush  (IFlush),
    .IIn     (IIn),
    .IValid  (IValid),
    .IStall  (IStall),
    .MemReq  (MemReq),
    .MemAddr (MemAddr),
    .MemAck  (MemAck),
    .MemData (MemData)
  );

  initial forever #5 PHI1 = ~PHI1;

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return 32'h1000_0000 + ((a - 32'h40) >> 2);
  endfunction

  task automatic clr_model();
    for (int i = 0; i < LN; i++) mv[i] = 1'b0;
  endtask

  // one fetch; fl = edge index carrying IFlush
  // (0 = request edge, -1 = none)
  task automatic fetch(
    input logic [31:0] a,
    input int          waits,
    input int          fl
  );
    int          ix;
    logic [31:0] tg;
    logic [31:0] wa;
    bit          hit;
    int          edges;
    int          wc;
    int          nack;
    int          stl;
    bit          aok;
    bit          rok;
    bit          ffill;
    bit          ack;
    logic [31:0] ea;
    ix = int'((a >> 4) & 32'hF);
    tg = a >> 8;
    wa = {a[31:2], 2'b00};
    if (fl == 0) clr_model();
    hit = mv[ix] && (mt[ix] == tg);
    IReq = 1'b1;
    IAddr = a;
    IFlush = (fl == 0);
    MemAck = 1'b0;
    @(negedge PHI1);
    @(posedge PHI1);
    IReq = 1'b0;
    IFlush = 1'b0;
    IAddr = $urandom;
    edges = 1;
    wc = 0;
    nack = 0;
    stl = 0;
    aok = 1'b1;
    rok = 1'b1;
    ffill = 1'b0;
    ea = {a[31:4], 4'h0};
    if (hit) begin
      chk("hit_valid", 32'(IValid), 32'd1);
      chk("hit_data", IIn, mem_word(wa));
      chk("hit_stall", 32'(IStall), 32'd0);
      chk("hit_memreq", 32'(MemReq), 32'd0);
    end else begin
      while (!IValid && edges < 200) begin
        if (IStall) stl++;
        ack = 1'b0;
        if (nack < WP) begin
          if (!MemReq) rok = 1'b0;
          if (MemAddr !== ea) aok = 1'b0;
        end
        if (MemReq && wc == waits) begin
          ack = 1'b1;
          wc = 0;
          MemAck = 1'b1;
          MemData = mem_word(MemAddr);
        end else begin
          if (MemReq) wc++;
          MemAck = MemReq ? 1'b0 : 1'($urandom % 2);
          MemData = $urandom;
        end
        IFlush = (fl == edges);
        if (IFlush) ffill = 1'b1;
        IReq = 1'($urandom % 2);
        IAddr = $urandom;
        @(negedge PHI1);
        edges++;
        if (ack) begin
          nack++;
          ea += 32'd4;
        end
        @(posedge PHI1);
        IFlush = 1'b0;
      end
      IReq = 1'b0;
      chk("miss_valid", 32'(IValid), 32'd1);
      chk("miss_data", IIn, mem_word(wa));
      chk("miss_edges", 32'(edges),
          32'(2 + WP * (waits + 1)));
      chk("stall_edges", 32'(stl),
          32'(1 + WP * (waits + 1)));
      chk("acks", 32'(nack), 32'(WP));
      chk("memaddr_seq", 32'(aok), 32'd1);
      chk("memreq_held", 32'(rok), 32'd1);
      chk("stall_clear", 32'(IStall), 32'd0);
      chk("memreq_end", 32'(MemReq), 32'd0);
      if (ffill) clr_model();
      else begin
        mv[ix] = 1'b1;
        mt[ix] = tg;
      end
    end
    IReq = 1'b0;
    MemAck = 1'($urandom % 2);
    @(negedge PHI1);
    @(posedge PHI1);
    chk("one_pulse", 32'(IValid), 32'd0);
    chk("iin_hold", IIn, mem_word(wa));
    chk("idle_memreq", 32'(MemReq), 32'd0);
    MemAck = 1'b0;
  endtask

  // start a refill, take one ack, then reset mid-fill
  task automatic rst_mid(input logic [31:0] a);
    IReq = 1'b1;
    IAddr = a;
    @(negedge PHI1);
    @(posedge PHI1);
    IReq = 1'b0;
    chk("rm_stall", 32'(IStall), 32'd1);
    MemAck = 1'b1;
    MemData = mem_word(MemAddr);
    @(negedge PHI1);
    @(posedge PHI1);
    MemAck = 1'b0;
    #1 MRST = 1'b1;
    #1;
    chk("rm_memreq", 32'(MemReq), 32'd0);
    chk("rm_istall", 32'(IStall), 32'd0);
    chk("rm_ivalid", 32'(IValid), 32'd0);
    chk("rm_memaddr", MemAddr, 32'd0);
    #1 MRST = 1'b0;
    clr_model();
    @(posedge PHI1);
  endtask

  initial begin
    logic [31:0] ra;
    int          rw;
    int          rf;
    clr_model();
    #2 MRST = 1'b1;
    repeat (2) @(posedge PHI1);
    chk("rst_iin", IIn, 32'd0);
    chk("rst_ivalid", 32'(IValid), 32'd0);
    chk("rst_istall", 32'(IStall), 32'd0);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    #1 MRST = 1'b0;
    @(posedge PHI1);

    fetch(32'h40, 0, -1);
    fetch(32'h44, 0, -1);
    fetch(32'h140, 0, -1);
    fetch(32'h40, 0, -1);
    fetch(32'hC0, 3, -1);
    fetch(32'hC8, 0, -1);
    fetch(32'h80, 0, 2);
    fetch(32'h80, 0, -1);
    fetch(32'h84, 1, 0);
    fetch(32'h84, 0, -1);
    rst_mid(32'h200);
    fetch(32'h200, 0, -1);
    fetch(32'h20C, 0, -1);

    for (int n = 0; n < 80; n++) begin
      ra = (32'($urandom_range(0, 3)) << 8) |
           (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      rw = $urandom_range(0, 2);
      rf = ($urandom % 8 == 0) ?
           int'($urandom_range(0, 3)) : -1;
      fetch(ra, rw, rf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, line-based instruction cache that replaces the flat single-word instruction memory in the DLX fetch stage. Serves fetches from an on-chip data/tag array. On a miss, stalls fetch and refills a whole line word-by-word from external memory over a req/ack handshake. Adds line geometry parameters, valid/tag tracking, a refill FSM and a global flush, none of which the flat array has.

## Interface
- ADDR_W, 32: byte-address width.
- DATA_W, 32: instruction word width.
- LINES, 16: number of cache lines (power of 2, ≥2).
- WPL, 4: words per line (power of 2, ≥2).
- PHI1  in  1  clock; all state updates on negedge PHI1.
- MRST  in  1  reset, asynchronous, active-high.
- IReq  in  1  fetch request, sampled each edge.
- IAddr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- IFlush  in  1  invalidate all lines (one-cycle pulse).
- IIn  out  DATA_W  fetched instruction, registered.
- IValid  out  1  one-cycle pulse: IIn holds the word for the accepted request.
- IStall  out  1  high while a refill is in progress; fetch stage must hold.
- MemReq  out  1  external word read request.
- MemAddr  out  ADDR_W  external word byte address (word-aligned).
- MemAck  in  1  external word available this edge.
- MemData  in  DATA_W  external read data, valid with MemAck.

## Operation
- Address split: WOFF = IAddr[2 +: log2(WPL)], IDX = next log2(LINES) bits, TAG = remaining upper bits (ADDR_W − 2 − log2 WPL − log2 LINES bits).
- Per line: valid bit, tag, WPL data words. Valid bits all clear after reset.
- FSM states: IDLE, FILL, RESP.
- IDLE, IReq=1, hit (valid[IDX] and tag match): IIn←data[IDX][WOFF], IValid=1; stay IDLE.
- IDLE, IReq=1, miss: latch IDX/TAG/WOFF; IStall=1, MemReq=1, MemAddr=line base (TAG,IDX,0,00); cnt←0; →FILL.
- FILL: on each edge with MemAck=1, write MemData to data[IDX][cnt], cnt++, MemAddr advances one word; MemReq stays high. Ack on word WPL−1: MemReq←0, →RESP.
- RESP: valid[IDX]←1 (unless flush pending), tag stored, IIn←requested word, IValid=1, IStall←0; →IDLE.
- IReq/IAddr ignored while IStall=1; the latched address is the one served.
- IFlush in IDLE: clear all valid bits on that edge; a simultaneous IReq is treated as a miss.
- IFlush during FILL/RESP: clear all valid bits, set flush-pending; refill completes, requested word returned, but line left invalid. Pending cleared on return to IDLE.
- MemAck while MemReq=0 is ignored.

## Timing
- Reset values: IIn=0, IValid=0, IStall=0, MemReq=0, MemAddr=0, state IDLE, all valid=0, cnt=0, flush-pending=0.
- MRST mid-refill: aborts immediately (async); MemReq drops without waiting for ack; partial line stays invalid.
- Hit latency: 1 edge (request sampled edge N, IValid high after edge N).
- Miss latency: 1 edge to issue + WPL acked edges + 1 RESP edge; zero-wait memory gives WPL+2 edges.
- MemAddr/MemReq stable until the acking edge; new MemAddr appears after that edge.
- IValid is never high on two consecutive edges for a single request; with IReq=0, IIn holds its last value.

## Structure
- Package icache_pkg: state encoding (IDLE/FILL/RESP), functions/localparams for WOFF_W, IDX_W, TAG_W derived from ADDR_W/LINES/WPL.
- One sub-module: icache_line_ram — LINES×WPL×DATA_W array with one write port (IDX, word) and one read port, no reset on contents. Valid/tag arrays and FSM stay in the top.

## Test plan
- Reset then IReq, IAddr=0x40, memory returns 0x1000_0000+word, zero wait → IStall 1 for 5 edges, MemAddr 0x40,0x44,0x48,0x4C, IValid with IIn=0x1000_0000.
- Re-fetch 0x44 after fill → IValid next edge, IIn=0x1000_0001, no MemReq.
- Conflict: fetch 0x40 then 0x140 (same IDX, different TAG) → second misses and refills; fetching 0x40 again misses.
- MemAck wait of 3 cycles per word → MemAddr held stable across waits, miss latency 1+4×4+1 edges, correct data.
- IFlush pulse during FILL of 0x80 → requested word still returned; immediate re-fetch of 0x80 misses.
- MRST asserted mid-FILL → MemReq, IStall, IValid low asynchronously; subsequent fetch of same line misses.
